// File: rtl/dual_fetch_queue_pkg.sv
// Shared types and constants for the dual-issue fetch front end.
// The NOP-squash option is selected by the FETCH_NOP_SQUASH_EN macro in the top.
package dual_fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam int PC_W = 10;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_BLT = 6'h06;
  localparam logic [5:0] OP_BGE = 6'h07;
  localparam logic [5:0] OP_NOP = 6'b111111;

  localparam logic [XLEN-1:0] NOP_WORD = {OP_NOP, 26'd0};

  // The pc field is sized by PC_W, so the top's ADDR_W must equal it.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [PC_W-1:0] pc;
  } fq_entry_t;

  function automatic logic is_nop(input logic [XLEN-1:0] w);
    return w[31:26] == OP_NOP;
  endfunction

  function automatic logic is_ctrl_flow(input logic [XLEN-1:0] w);
    return (w[31:26] == OP_BEQ) || (w[31:26] == OP_BNE) ||
           (w[31:26] == OP_BLT) || (w[31:26] == OP_BGE) ||
           (w[31:26] == OP_J)   || (w[31:26] == OP_JAL);
  endfunction

endpackage

// File: rtl/dual_fetch_queue_if.sv
// Bundle of instruction-memory, redirect and decode-side signals of the fetch stage.
interface dual_fetch_queue_if #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8
);
  import dual_fetch_queue_pkg::*;

  logic [ADDR_W-1:0]       imem_addr0;
  logic [ADDR_W-1:0]       imem_addr1;
  logic [XLEN-1:0]         imem_rd0;
  logic [XLEN-1:0]         imem_rd1;
  logic                    redirect_valid;
  logic [ADDR_W-1:0]       redirect_pc;
  logic                    dec_ready;
  logic                    out_valid0;
  logic                    out_valid1;
  logic [XLEN-1:0]         out_instr0;
  logic [XLEN-1:0]         out_instr1;
  logic [ADDR_W-1:0]       out_pc0;
  logic [ADDR_W-1:0]       out_pc1;
  logic [$clog2(DEPTH):0]  q_count;

  // Handshake: a slot transfers on a clock edge where out_validN=1 and
  // dec_ready=1; decode takes every valid slot at once, out_valid1 implies out_valid0.
  modport master (
    output imem_addr0, imem_addr1, out_valid0, out_valid1,
           out_instr0, out_instr1, out_pc0, out_pc1, q_count,
    input  imem_rd0, imem_rd1, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_addr0, imem_addr1, out_valid0, out_valid1,
           out_instr0, out_instr1, out_pc0, out_pc1, q_count,
    output imem_rd0, imem_rd1, redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/dual_fetch_queue_fetch_fifo2.sv
// Circular buffer accepting 0-2 entries and releasing 0-2 entries per cycle.
// Storage resets to NOP entries so the head reads as a NOP out of reset.
module fetch_fifo2
  import dual_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [1:0]    push_cnt,
  input  fq_entry_t     push0,
  input  fq_entry_t     push1,
  input  logic [1:0]    pop_cnt,
  output fq_entry_t     head0,
  output fq_entry_t     head1,
  output logic [CW-1:0] count
);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  fq_entry_t     mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{instr: NOP_WORD, pc: '0};
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_cnt != 2'd0) mem[tail] <= push0;
      if (push_cnt == 2'd2) mem[tail + PW'(1)] <= push1;
      tail  <= tail + PW'(push_cnt);
      head  <= head + PW'(pop_cnt);
      count <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  assign head0 = mem[head];
  assign head1 = mem[head + PW'(1)];

endmodule

// File: rtl/dual_fetch_queue.sv
// Two-wide fetch stage: pc/fetch control in front of a 2-in/2-out instruction queue.
// Optional FETCH_NOP_SQUASH_EN drops fetched NOP words before they are enqueued.
module dual_fetch_queue
  import dual_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = PC_W
) (
  input  logic               clk1,
  input  logic               reset,
  dual_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic [CW-1:0]     count;
  logic [CW:0]       free_slots;
  logic              valid0;
  logic              valid1;
  logic              can_fetch;
  logic [1:0]        pop_cnt;
  logic [1:0]        push_cnt;
  fq_entry_t         push0;
  fq_entry_t         push1;
  fq_entry_t         w0;
  fq_entry_t         w1;
  fq_entry_t         head0;
  fq_entry_t         head1;

  assign pc_plus1 = pc + ADDR_W'(1);

  // Redirect hides the queue immediately so no stale instruction leaks out.
  assign valid0  = !bus.redirect_valid && (count != '0);
  assign valid1  = !bus.redirect_valid && (count >= CW'(2));
  assign pop_cnt = bus.dec_ready ? ({1'b0, valid0} + {1'b0, valid1}) : 2'd0;

  // Space freed by this cycle's pop counts toward the current fetch.
  assign free_slots = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(pop_cnt);
  assign can_fetch  = !bus.redirect_valid && (free_slots >= (CW+1)'(2));

`ifdef FETCH_NOP_SQUASH_EN
  logic keep0;
  logic keep1;
  assign keep0 = !is_nop(bus.imem_rd0);
  assign keep1 = !is_nop(bus.imem_rd1);
`endif

  always_comb begin
    w0       = '{instr: bus.imem_rd0, pc: pc};
    w1       = '{instr: bus.imem_rd1, pc: pc_plus1};
    push_cnt = 2'd0;
    push0    = w0;
    push1    = w1;
`ifdef FETCH_NOP_SQUASH_EN
    if (can_fetch) push_cnt = {1'b0, keep0} + {1'b0, keep1};
    if (!keep0) push0 = w1;
`else
    if (can_fetch) push_cnt = 2'd2;
`endif
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (bus.redirect_valid) begin
      pc <= bus.redirect_pc;
    end else if (can_fetch) begin
      pc <= pc + ADDR_W'(2);
    end
  end

  fetch_fifo2 #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk1),
    .rst      (reset),
    .flush    (bus.redirect_valid),
    .push_cnt (push_cnt),
    .push0    (push0),
    .push1    (push1),
    .pop_cnt  (pop_cnt),
    .head0    (head0),
    .head1    (head1),
    .count    (count)
  );

  assign bus.imem_addr0 = pc;
  assign bus.imem_addr1 = pc_plus1;
  assign bus.out_valid0 = valid0;
  assign bus.out_valid1 = valid1;
  assign bus.out_instr0 = head0.instr;
  assign bus.out_instr1 = head1.instr;
  assign bus.out_pc0    = head0.pc;
  assign bus.out_pc1    = head1.pc;
  assign bus.q_count    = count;

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Randomised bench for dual_fetch_queue against a queue-based reference model.
// Build with or without FETCH_NOP_SQUASH_EN; the model follows the same macro.
module tb_dual_fetch_queue;
  import dual_fetch_queue_pkg::*;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 10;
  localparam int AMOD   = 1 << ADDR_W;
`ifdef FETCH_NOP_SQUASH_EN
  localparam bit SQUASH = 1'b1;
`else
  localparam bit SQUASH = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk1  = 1'b0;
  logic reset = 1'b0;
  always #5 clk1 = ~clk1;

  dual_fetch_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  dual_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [AMOD];
  assign bus.imem_rd0 = mem[bus.imem_addr0];
  assign bus.imem_rd1 = mem[bus.imem_addr1];

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [9:0]  pc;
  } ment_t;

  ment_t mq[$];
  int    mpc;
  int    chk_cnt  = 0;
  int    pass_cnt = 0;
  bit    chk_en   = 1'b0;
  bit    seen_pc2_nop;
  bit    seen_pc3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] add_word(input int i);
    logic [9:0] t;
    t = i[9:0];
    return {6'b000000, t, 16'h1820};
  endfunction

  // ---------------- compare + model step ----------------
  bit    ev0, ev1;
  int    npop, nfree, a;
  ment_t e;

  always @(negedge clk1) begin
    if (chk_en) begin
      if (reset) begin
        chk("rst_valid0", bus.out_valid0, 1'b0);
        chk("rst_valid1", bus.out_valid1, 1'b0);
        chk("rst_qcount", bus.q_count, 0);
        chk("rst_addr0", bus.imem_addr0, 0);
        chk("rst_addr1", bus.imem_addr1, 1);
        chk("rst_instr0", bus.out_instr0, NOP_WORD);
        chk("rst_instr1", bus.out_instr1, NOP_WORD);
        chk("rst_pc0", bus.out_pc0, 0);
        chk("rst_pc1", bus.out_pc1, 0);
        mq.delete();
        mpc = 0;
      end else begin
        ev0 = !bus.redirect_valid && (mq.size() >= 1);
        ev1 = !bus.redirect_valid && (mq.size() >= 2);
        chk("valid0", bus.out_valid0, ev0);
        chk("valid1", bus.out_valid1, ev1);
        if (ev0) begin
          chk("instr0", bus.out_instr0, mq[0].instr);
          chk("pc0", bus.out_pc0, mq[0].pc);
        end
        if (ev1) begin
          chk("instr1", bus.out_instr1, mq[1].instr);
          chk("pc1", bus.out_pc1, mq[1].pc);
        end
        chk("q_count", bus.q_count, mq.size());
        chk("addr0", bus.imem_addr0, mpc);
        chk("addr1", bus.imem_addr1, (mpc + 1) % AMOD);

        if (bus.out_valid0 && bus.out_pc0 == 10'd2 && bus.out_instr0 == NOP_WORD) seen_pc2_nop = 1'b1;
        if (bus.out_valid1 && bus.out_pc1 == 10'd2 && bus.out_instr1 == NOP_WORD) seen_pc2_nop = 1'b1;
        if ((bus.out_valid0 && bus.out_pc0 == 10'd3) || (bus.out_valid1 && bus.out_pc1 == 10'd3)) seen_pc3 = 1'b1;

        // Advance the model by the coming clock edge.
        if (bus.redirect_valid) begin
          mq.delete();
          mpc = int'(bus.redirect_pc);
        end else begin
          npop = bus.dec_ready ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
          for (int k = 0; k < npop; k++) void'(mq.pop_front());
          nfree = DEPTH - mq.size();
          if (nfree >= 2) begin
            for (int k = 0; k < 2; k++) begin
              a = (mpc + k) % AMOD;
              e.instr = mem[a];
              e.pc    = a[9:0];
              if (!(SQUASH && e.instr[31:26] == 6'b111111)) mq.push_back(e);
            end
            mpc = (mpc + 2) % AMOD;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic fill_add();
    for (int i = 0; i < AMOD; i++) mem[i] = add_word(i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    fill_add();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b0;
    #2;
    reset  = 1'b1;
    chk_en = 1'b1;
    step(2);
    chk("lit_rst_qcount", bus.q_count, 0);
    chk("lit_rst_valid0", bus.out_valid0, 0);
    chk("lit_rst_instr0", bus.out_instr0, 32'hFC00_0000);

    // Streaming with decode always ready.
    reset = 1'b0;
    bus.dec_ready = 1'b1;
    step(1);
    chk("lit_first_pc0", bus.out_pc0, 0);
    chk("lit_first_pc1", bus.out_pc1, 1);
    step(1);
    chk("lit_second_pc0", bus.out_pc0, 2);
    chk("lit_second_pc1", bus.out_pc1, 3);
    step(3);

    // Backpressure fill then drain.
    bus.dec_ready = 1'b0;
    do_reset();
    step(10);
    chk("lit_full_qcount", bus.q_count, 8);
    chk("lit_full_addr0", bus.imem_addr0, 8);
    bus.dec_ready = 1'b1;
    #1;
    chk("lit_drain_pc0", bus.out_pc0, 0);
    chk("lit_drain_pc1", bus.out_pc1, 1);
    step(1);
    chk("lit_drain2_pc0", bus.out_pc0, 2);
    step(2);

    // Redirect to 20 with stale pcs in the queue.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'd20;
    #1;
    chk("lit_redir_valid0", bus.out_valid0, 0);
    step(1);
    bus.redirect_valid = 1'b0;
    chk("lit_redir_qcount", bus.q_count, 0);
    chk("lit_redir_addr0", bus.imem_addr0, 20);
    step(1);
    chk("lit_redir_pc0", bus.out_pc0, 20);
    chk("lit_redir_pc1", bus.out_pc1, 21);
    step(2);

    // Address wrap at the top of memory.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'd1023;
    step(1);
    bus.redirect_valid = 1'b0;
    step(1);
    chk("lit_wrap_pc0", bus.out_pc0, 1023);
    chk("lit_wrap_pc1", bus.out_pc1, 0);
    step(1);
    chk("lit_wrap2_pc0", bus.out_pc0, 1);
    chk("lit_wrap2_pc1", bus.out_pc1, 2);
    step(2);

    // NOP at address 2.
    mem[2] = NOP_WORD;
    do_reset();
    seen_pc2_nop = 1'b0;
    seen_pc3     = 1'b0;
    step(6);
    chk("lit_nop_pc2_seen", seen_pc2_nop, !SQUASH);
    chk("lit_nop_pc3_seen", seen_pc3, 1'b1);
    mem[2] = add_word(2);

    // Random traffic with sprinkled NOPs and redirects.
    for (int i = 0; i < AMOD; i++)
      mem[i] = ($urandom_range(0, 99) < 15) ? NOP_WORD : add_word(i);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.dec_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 5) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, AMOD - 1));
      end else begin
        bus.redirect_valid = 1'b0;
      end
      step(1);
    end
    bus.redirect_valid = 1'b0;

    // Reset between clock edges with a full queue.
    fill_add();
    bus.dec_ready = 1'b0;
    do_reset();
    step(6);
    chk("lit_pre_async_qcount", bus.q_count, 8);
    @(posedge clk1);
    #3;
    reset = 1'b1;
    #1;
    chk("lit_async_qcount", bus.q_count, 0);
    chk("lit_async_valid0", bus.out_valid0, 0);
    chk("lit_async_valid1", bus.out_valid1, 0);
    chk("lit_async_addr0", bus.imem_addr0, 0);
    step(2);
    reset = 1'b0;
    bus.dec_ready = 1'b1;
    step(4);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
